// File: rtl/vga_pkg.sv
// Default 640x480@60 timing constants, derived totals and sync windows, coordinate type.
// The top level overrides the defaults through its own parameters.
package vga_pkg;

    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    localparam int CLK_DIV_DEF   = 4;
    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF      = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF      = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
    localparam int H_SYNC_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
    localparam int V_SYNC_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

    // Inclusive window test on a coordinate; both bounds are elaboration constants.
    function automatic logic in_span(input coord_t v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_if.sv
// Coordinate/sync bundle from the timing generator to the renderers and connector.
// master = vga_sync, slave = any drawing block or colour mux.
interface vga_sync_if;
    import vga_pkg::*;

    coord_t x;
    coord_t y;
    logic   hsync;
    logic   vsync;
    logic   video_on;
    logic   p_tick;
    logic   frame_tick;

    modport master (
        output x, y, hsync, vsync, video_on, p_tick, frame_tick
    );

    modport slave (
        input x, y, hsync, vsync, video_on, p_tick, frame_tick
    );

endinterface

// File: rtl/mod_counter.sv
// Modulo-N up counter with enable; tc flags the registered count at N-1.
// Latency: count updates on the edge after en; tc is combinational from the count register.
// Backpressure: none; en is the only advance condition.
module mod_counter #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/vga_sync.sv
// Pixel-timing generator: clock divider plus x/y scan counters with registered hsync/vsync/video_on.
// Latency: sync/video decode uses next-state x/y, so they change on the same edge as the coordinates.
// Backpressure: none; free-running source, consumers qualify on p_tick.
module vga_sync
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic       clk,
    input  logic       reset,
    vga_sync_if.master vga
);

    localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             div_tc;
    logic             p_tick;
    coord_t           x_cnt;
    coord_t           y_cnt;
    logic             x_tc;
    logic             y_tc;
    logic             y_en;
    coord_t           x_nxt;
    coord_t           y_nxt;
    logic             hsync_q;
    logic             vsync_q;
    logic             video_q;

    mod_counter #(.N(CLK_DIV), .W(DIV_W)) u_div (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .count (div_cnt),
        .tc    (div_tc)
    );

    mod_counter #(.N(H_TOTAL), .W(COORD_W)) u_x (
        .clk   (clk),
        .reset (reset),
        .en    (div_tc),
        .count (x_cnt),
        .tc    (x_tc)
    );

    assign y_en = div_tc && x_tc;

    mod_counter #(.N(V_TOTAL), .W(COORD_W)) u_y (
        .clk   (clk),
        .reset (reset),
        .en    (y_en),
        .count (y_cnt),
        .tc    (y_tc)
    );

    assign p_tick = (div_cnt == DIV_LAST);

    // Lookahead of the counters' next state, so the decode registers line up with x/y.
    always_comb begin
        x_nxt = x_cnt;
        y_nxt = y_cnt;
        if (div_tc) begin
            x_nxt = x_tc ? '0 : x_cnt + 1'b1;
        end
        if (y_en) begin
            y_nxt = y_tc ? '0 : y_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            video_q <= 1'b1;
        end else begin
            hsync_q <= !in_span(x_nxt, H_SYNC_START, H_SYNC_END);
            vsync_q <= !in_span(y_nxt, V_SYNC_START, V_SYNC_END);
            video_q <= (int'(x_nxt) < H_DISPLAY) && (int'(y_nxt) < V_DISPLAY);
        end
    end

    assign vga.x          = x_cnt;
    assign vga.y          = y_cnt;
    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.video_on   = video_q;
    assign vga.p_tick     = p_tick;
    assign vga.frame_tick = p_tick && x_tc && y_tc;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: default-timing instance (a) and a tiny override instance (b).
// Expected points are queued ahead of time and popped by a negedge monitor when their cycle arrives.
module tb_vga_sync;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_a_q = 1'b0;
    logic rst_b_q = 1'b0;

    vga_sync_if va();
    vga_sync_if vb();

    vga_sync u_a (
        .clk   (clk),
        .reset (rst_a),
        .vga   (va)
    );

    vga_sync #(
        .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_b (
        .clk   (clk),
        .reset (rst_b),
        .vga   (vb)
    );

    always #5 clk = ~clk;

    // flags field order: {hsync, vsync, video_on, p_tick, frame_tick}
    typedef struct {
        int         t;
        logic [9:0] x;
        logic [9:0] y;
        logic [4:0] f;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int vectors     = 0;
    int miscompares = 0;

    int ta = 0, tb_t = 0;
    int hs_run_a = 0, hs_fall_a = -1;
    logic hs_prev_a = 1'b1;
    int hs_run_b = 0, vs_run_b = 0, hs_fall_b = -1, ft_last_b = -1;
    logic hs_prev_b = 1'b1;

    function automatic exp_t mk(input int t, input int x, input int y, input logic [4:0] f);
        exp_t e;
        e.t = t;
        e.x = 10'(x);
        e.y = 10'(y);
        e.f = f;
        return e;
    endfunction

    task automatic chk_point(input string nm, input int t, input exp_t e,
                             input logic [9:0] x, input logic [9:0] y, input logic [4:0] f);
        vectors++;
        if (t != e.t || {x, y, f} !== {e.x, e.y, e.f}) begin
            miscompares++;
            $display("FAIL %s t=%0d: got x=%0d y=%0d hs/vs/vo/pt/ft=%b, required t=%0d x=%0d y=%0d hs/vs/vo/pt/ft=%b",
                     nm, t, x, y, f, e.t, e.x, e.y, e.f);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    always @(posedge clk) begin
        rst_a_q <= rst_a;
        rst_b_q <= rst_b;
    end

    always @(negedge clk) begin
        exp_t e;
        // instance a
        if (rst_a_q) begin
            ta = 0; hs_run_a = 0; hs_fall_a = -1; hs_prev_a = 1'b1;
            chk_point("a reset", 0, mk(0, 0, 0, 5'b11100), va.x, va.y,
                      {va.hsync, va.vsync, va.video_on, va.p_tick, va.frame_tick});
        end else begin
            ta++;
            if (!va.hsync) hs_run_a++;
            else if (hs_run_a > 0) begin
                check_int("a hsync low clocks", hs_run_a, 384);
                hs_run_a = 0;
            end
            if (hs_prev_a && !va.hsync) begin
                if (hs_fall_a >= 0) check_int("a line period", ta - hs_fall_a, 3200);
                hs_fall_a = ta;
            end
            hs_prev_a = va.hsync;
        end
        while (qa.size() > 0 && qa[0].t <= ta) begin
            e = qa.pop_front();
            chk_point("a point", ta, e, va.x, va.y,
                      {va.hsync, va.vsync, va.video_on, va.p_tick, va.frame_tick});
        end
        // instance b
        if (rst_b_q) begin
            tb_t = 0; hs_run_b = 0; vs_run_b = 0; hs_fall_b = -1; ft_last_b = -1; hs_prev_b = 1'b1;
            chk_point("b reset", 0, mk(0, 0, 0, 5'b11100), vb.x, vb.y,
                      {vb.hsync, vb.vsync, vb.video_on, vb.p_tick, vb.frame_tick});
        end else begin
            tb_t++;
            if (!vb.hsync) hs_run_b++;
            else if (hs_run_b > 0) begin
                check_int("b hsync low clocks", hs_run_b, 4);
                hs_run_b = 0;
            end
            if (!vb.vsync) vs_run_b++;
            else if (vs_run_b > 0) begin
                check_int("b vsync low clocks", vs_run_b, 24);
                vs_run_b = 0;
            end
            if (hs_prev_b && !vb.hsync) begin
                if (hs_fall_b >= 0) check_int("b line period", tb_t - hs_fall_b, 24);
                hs_fall_b = tb_t;
            end
            hs_prev_b = vb.hsync;
            if (vb.frame_tick) begin
                if (ft_last_b >= 0) check_int("b frame period", tb_t - ft_last_b, 168);
                ft_last_b = tb_t;
            end
        end
        while (qb.size() > 0 && qb[0].t <= tb_t) begin
            e = qb.pop_front();
            chk_point("b point", tb_t, e, vb.x, vb.y,
                      {vb.hsync, vb.vsync, vb.video_on, vb.p_tick, vb.frame_tick});
        end
    end

    task automatic push_b_start();
        qb.push_back(mk(1,   0,  0, 5'b11110));
        qb.push_back(mk(2,   1,  0, 5'b11100));
        qb.push_back(mk(24,  0,  1, 5'b11100));
        qb.push_back(mk(167, 11, 6, 5'b11011));
        qb.push_back(mk(168, 0,  0, 5'b11100));
    endtask

    initial begin
        // default timing: pixel P = t/4, x = P%800, y = P/800
        qa.push_back(mk(1,    0,   0, 5'b11100));
        qa.push_back(mk(3,    0,   0, 5'b11110));
        qa.push_back(mk(4,    1,   0, 5'b11100));
        qa.push_back(mk(7,    1,   0, 5'b11110));
        qa.push_back(mk(8,    2,   0, 5'b11100));
        qa.push_back(mk(2559, 639, 0, 5'b11110));
        qa.push_back(mk(2560, 640, 0, 5'b11000));
        qa.push_back(mk(2623, 655, 0, 5'b11010));
        qa.push_back(mk(2624, 656, 0, 5'b01000));
        qa.push_back(mk(3007, 751, 0, 5'b01010));
        qa.push_back(mk(3008, 752, 0, 5'b11000));
        qa.push_back(mk(3199, 799, 0, 5'b11010));
        qa.push_back(mk(3200, 0,   1, 5'b11100));
        qa.push_back(mk(3204, 1,   1, 5'b11100));
        qa.push_back(mk(6400, 0,   2, 5'b11100));

        // small timing: P = t/2, x = P%12, y = (P/12)%7
        push_b_start();
        qb.pop_back();
        qb.pop_back();
        qb.pop_back();
        qb.push_back(mk(15,  7,  0, 5'b11110));
        qb.push_back(mk(16,  8,  0, 5'b11000));
        qb.push_back(mk(18,  9,  0, 5'b01000));
        qb.push_back(mk(21,  10, 0, 5'b01010));
        qb.push_back(mk(22,  11, 0, 5'b11000));
        qb.push_back(mk(23,  11, 0, 5'b11010));
        qb.push_back(mk(24,  0,  1, 5'b11100));
        qb.push_back(mk(96,  0,  4, 5'b11000));
        qb.push_back(mk(120, 0,  5, 5'b10000));
        qb.push_back(mk(144, 0,  6, 5'b11000));
        qb.push_back(mk(167, 11, 6, 5'b11011));
        qb.push_back(mk(168, 0,  0, 5'b11100));
        qb.push_back(mk(335, 11, 6, 5'b11011));
        qb.push_back(mk(336, 0,  0, 5'b11100));
        qb.push_back(mk(756, 6,  3, 5'b11100));
        qb.push_back(mk(757, 6,  3, 5'b11110));

        repeat (10) @(posedge clk);
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;

        fork
            begin
                repeat (6500) @(posedge clk);
            end
            begin
                // one-clock reset mid-frame at x=6, y=3
                repeat (757) @(posedge clk);
                #2 rst_b = 1'b1;
                @(posedge clk);
                #2 rst_b = 1'b0;
                push_b_start();
                repeat (345) @(posedge clk);
            end
        join

        @(negedge clk);
        check_int("a points left unreached", qa.size(), 0);
        check_int("b points left unreached", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
